// File: rtl/day1_pkg.sv
// Shared types and constants for the day-1 dial engine.
// Holds the FSM state enum, default parameters and a width helper.
package day1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_APPLY,
    ST_DONE
  } state_e;

  localparam int DEF_DIAL_SIZE   = 100;
  localparam int DEF_START_POS   = 50;
  localparam int DEF_MAG_WIDTH   = 16;
  localparam int DEF_COUNT_WIDTH = 32;

  // Width of a position register: max(1, clog2(n)).
  function automatic int pos_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/day1_seq_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, MSB first.
// Ports: clock, clear (sync), start, dividend -> busy, final_step, quotient, remainder.
module day1_seq_divider
  import day1_pkg::*;
#(
  parameter int DIVD_W  = 17,
  parameter int DIVISOR = 100
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  output logic              busy,
  output logic              final_step,
  output logic [DIVD_W-1:0] quotient,
  output logic [DIVD_W-1:0] remainder
);

  localparam int TW    = DIVD_W + 1;
  localparam int CNT_W = $clog2(DIVD_W + 1);
  localparam logic [TW-1:0] DIV_E = TW'(DIVISOR);

  logic [DIVD_W-1:0] dvd_q, dvd_d;
  logic [DIVD_W-1:0] quo_q, quo_d;
  logic [DIVD_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]     trial;
  logic [TW-1:0]     diff;
  logic              ge;

  always_comb begin
    dvd_d = dvd_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    // Partial remainder stays below the divisor, so one extra bit
    // is enough to hold the shifted trial value.
    trial = {rem_q, dvd_q[DIVD_W-1]};
    diff  = trial - DIV_E;
    ge    = (trial >= DIV_E);
    if (start) begin
      dvd_d = dividend;
      quo_d = '0;
      rem_d = '0;
      cnt_d = CNT_W'(DIVD_W);
    end else if (cnt_q != '0) begin
      rem_d = ge ? diff[DIVD_W-1:0] : trial[DIVD_W-1:0];
      quo_d = {quo_q[DIVD_W-2:0], ge};
      dvd_d = dvd_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy       = (cnt_q != '0);
  assign final_step = (cnt_q == CNT_W'(1));
  assign quotient   = quo_q;
  assign remainder  = rem_q;

endmodule

// File: rtl/day1_dial_engine.sv
// Handshaked dial solver: position, part-1 and part-2 zero counts.
// Ports: clock, clear, instruction_* in; position, part*_result, done out. Macro: DAY1_FAST_PATH_EN.
module day1_dial_engine
  import day1_pkg::*;
#(
  parameter int DIAL_SIZE   = DEF_DIAL_SIZE,
  parameter int START_POS   = DEF_START_POS,
  parameter int MAG_WIDTH   = DEF_MAG_WIDTH,
  parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
  localparam int POS_W  = pos_width(DIAL_SIZE),
  localparam int DIVD_W = MAG_WIDTH + 1
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   instruction_valid,
  output logic                   instruction_ready,
  input  logic                   direction,
  input  logic [MAG_WIDTH-1:0]   magnitude,
  input  logic                   instruction_last,
  output logic [POS_W-1:0]       position,
  output logic [COUNT_WIDTH-1:0] part1_result,
  output logic [COUNT_WIDTH-1:0] part2_result,
  output logic                   done
);

  localparam logic [DIVD_W-1:0] N_D     = DIVD_W'(DIAL_SIZE);
  localparam logic [POS_W-1:0]  START_P = POS_W'(START_POS);

  state_e                 state_q, state_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [COUNT_WIDTH-1:0] p1_q, p1_d;
  logic [COUNT_WIDTH-1:0] p2_q, p2_d;
  logic                   dir_q, dir_d;
  logic                   last_q, last_d;

  logic                   xfer;
  logic [DIVD_W-1:0]      pos_e, off, dvd;
  logic                   div_start, div_busy, div_final;
  logic [DIVD_W-1:0]      div_quo, div_rem;
  logic                   apply, app_dir;
  logic [DIVD_W-1:0]      app_q, app_rem, new_pos;

  assign xfer = instruction_valid && instruction_ready;

  // Left turns are solved as right turns on the mirrored dial.
  always_comb begin
    pos_e = DIVD_W'(pos_q);
    off   = (direction || pos_e == '0) ? pos_e : N_D - pos_e;
    dvd   = {1'b0, magnitude} + off;
  end

  day1_seq_divider #(
    .DIVD_W  (DIVD_W),
    .DIVISOR (DIAL_SIZE)
  ) u_div (
    .clock      (clock),
    .clear      (clear),
    .start      (div_start),
    .dividend   (dvd),
    .busy       (div_busy),
    .final_step (div_final),
    .quotient   (div_quo),
    .remainder  (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    dir_d     = dir_q;
    last_d    = last_q;
    div_start = 1'b0;
    apply     = 1'b0;
    app_dir   = dir_q;
    app_q     = div_quo;
    app_rem   = div_rem;
    new_pos   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          dir_d  = direction;
          last_d = instruction_last;
`ifdef DAY1_FAST_PATH_EN
          // Small turns cross zero at most once: D < 2N.
          if ({1'b0, magnitude} < N_D) begin
            apply   = 1'b1;
            app_dir = direction;
            if (dvd >= N_D) begin
              app_q   = DIVD_W'(1);
              app_rem = dvd - N_D;
            end else begin
              app_q   = '0;
              app_rem = dvd;
            end
            state_d = instruction_last ? ST_DONE : ST_IDLE;
          end else begin
            div_start = 1'b1;
            state_d   = ST_DIVIDE;
          end
`else
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
`endif
        end
      end
      ST_DIVIDE: begin
        if (div_final || !div_busy)
          state_d = ST_APPLY;
      end
      ST_APPLY: begin
        apply   = 1'b1;
        state_d = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      new_pos = (app_dir || app_rem == '0) ? app_rem : N_D - app_rem;
      pos_d   = new_pos[POS_W-1:0];
      p2_d    = p2_q + COUNT_WIDTH'(app_q);
      if (new_pos == '0)
        p1_d = p1_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      pos_q   <= START_P;
      p1_q    <= '0;
      p2_q    <= '0;
      dir_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
    end
  end

  assign instruction_ready = (state_q == ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign position          = pos_q;
  assign part1_result      = p1_q;
  assign part2_result      = p2_q;

endmodule
